// File: rtl/cp0_unit.sv
// Coprocessor-0 beside the M stage: SR, Cause, EPC, PRId,
// mtc0/mfc0/eret service and exception/interrupt request merge.
module cp0_unit #(
  parameter logic [31:0] PRID    = 32'h2023_0701,
  parameter logic [4:0]  EXC_INT = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_al;
  logic [31:0] epc_exc;
  logic [31:0] sr_v;
  logic [31:0] cause_v;

  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;

  // A delay-slot victim restarts at the branch that precedes it.
  assign pc_al   = {vpc[31:2], 2'b00};
  assign epc_exc = bd_in ? (pc_al - 32'd4) : pc_al;

  assign sr_v    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_v = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};
  assign epc_out = epc_q;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_int;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      exc_d = int_req ? EXC_INT : exc_code_in;
      bd_d  = bd_in;
      epc_d = epc_exc;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      unique case (1'b1)
        addr == 5'd12: begin
          im_d  = wdata[15:10];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        addr == 5'd14: epc_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == 5'd12: rdata = sr_v;
      addr == 5'd13: rdata = cause_v;
      addr == 5'd14: rdata = epc_q;
      addr == 5'd15: rdata = PRID;
      default: rdata = '0;
    endcase
  end

endmodule
